maxnet_feeder: RTL and testbench
================================

Name: maxnet_feeder

Overview:
- Initiator-side controller for the Maxnet winner-take-all core.
- Accepts one 32-bit IEEE-754 single-precision word per stream handshake and assembles a job: epsilon first, then num1..num4.
- Clears the core, drives its operands and start, waits for done, then returns the captured max word and the run latency on a valid/ready result port.
- Flags a timeout if the core never reports done.

Parameters:
- TIMEOUT_CYCLES, 1024: max RUN cycles to wait for mn_done before aborting.
- CNT_W, 16: width of the latency counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  feeder can accept an operand word.
- in_data  in  32  operand word, IEEE-754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_max  out  32  captured mn_max; 0 on timeout.
- out_cycles  out  CNT_W  RUN cycles from first mn_start=1 to done/timeout.
- out_timeout  out  1  job aborted without done.
- busy  out  1  high in CLEAR and RUN.
- mn_rst  out  1  active-high reset to Maxnet core.
- mn_start  out  1  start to Maxnet core.
- mn_epsilon  out  32  epsilon operand to core.
- mn_num1  out  32  operand 1 to core.
- mn_num2  out  32  operand 2 to core.
- mn_num3  out  32  operand 3 to core.
- mn_num4  out  32  operand 4 to core.
- mn_max  in  32  core result.
- mn_done  in  1  core completion.

Behaviour:
Reset (rst=0, asynchronous):
- State LOAD, load_cnt=0.
- Operand registers, out_max, out_cycles and out_timeout are 0; out_valid=0.
- mn_start=0; mn_rst=1 while rst=0.
- A reset mid-job discards everything; no partial result is produced.

State LOAD:
- in_ready=1; mn_rst=0.
- On in_valid&in_ready, store in_data by load_cnt: 0=epsilon, 1=num1, 2=num2, 3=num3, 4=num4.
- load_cnt increments per handshake; the 5th handshake (load_cnt=4) moves to CLEAR next cycle.
- in_ready is 0 in every other state.

State CLEAR (exactly 1 cycle):
- mn_rst=1, mn_start=0; latency counter cleared to 0; next state RUN.

State RUN:
- mn_rst=0, mn_start=1 (level, held until exit).
- Counter increments each cycle.
- If mn_done=1 at the edge: capture out_max=mn_max, out_cycles=counter+1, out_timeout=0, go RESULT.
- Else if counter+1 == TIMEOUT_CYCLES: out_max=0, out_cycles=TIMEOUT_CYCLES, out_timeout=1, go RESULT.
- If done and timeout occur in the same cycle, done wins.
- mn_start is 0 from the first RESULT cycle.

State RESULT:
- out_valid=1; outputs held stable.
- On out_valid&out_ready, go to LOAD with load_cnt=0; out_valid=0 next cycle.

Operand outputs:
- mn_num*/mn_epsilon are driven directly from the operand registers and stay stable from CLEAR through RESULT.
- They change only on LOAD handshakes.

No arithmetic is performed on operands; they pass through bit-exact. mn_max is captured bit-exact, including -0 and NaN.

Decomposition:
- Shared package maxnet_pkg: FP_W=32, the state encoding (LOAD, CLEAR, RUN, RESULT), and operand slot constants (SLOT_EPS=0 … SLOT_N4=4).
- Sub-module maxnet_job_regs: 5x32 operand register file with slot write and parallel outputs.
- FSM and counter live in the top module.

Test Plan (bench uses a behavioural Maxnet stub: done goes high N cycles after start and holds; max is a programmed word):
1. Reset/idle: hold rst=0 -> in_ready=0, out_valid=0, mn_rst=1, mn_start=0. Release rst -> in_ready=1.
2. Normal job: words 0x3E99999A, 0x3ECCCCCD, 0x3FCCCCCD, 0x3FD9999A, 0x3FA66666; stub N=7, max=0x3F4CCCCD. Required response:
   - mn_epsilon/mn_num1..4 equal those words.
   - mn_rst high for exactly 1 cycle, then mn_start high.
   - out_max=0x3F4CCCCD, out_cycles=7, out_timeout=0.
3. Timeout: stub never raises done, TIMEOUT_CYCLES=16 -> out_timeout=1, out_max=0, out_cycles=16, mn_start low in RESULT.
4. Backpressure:
   - Gap in_valid between words 2 and 3 -> load_cnt holds and operands load correctly.
   - out_ready=0 for 5 cycles -> out_valid and outputs stay stable; in_ready=0 until the result is accepted.
5. Done at timeout edge: stub N=16, TIMEOUT_CYCLES=16 -> out_timeout=0, out_cycles=16.
6. Reset mid-RUN: assert rst at RUN cycle 3 -> immediate mn_start=0, mn_rst=1. After release, a full new job completes normally with no stale out_valid.

Source files
------------

// File: rtl/maxnet_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | maxnet_pkg : shared widths, FSM encoding and operand slots for feeder   |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package maxnet_pkg;
  localparam int FP_W      = 32;
  localparam int SLOT_W    = 3;
  localparam int NUM_SLOTS = 5;

  localparam logic [SLOT_W-1:0] SLOT_EPS = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_N1  = 3'd1;
  localparam logic [SLOT_W-1:0] SLOT_N2  = 3'd2;
  localparam logic [SLOT_W-1:0] SLOT_N3  = 3'd3;
  localparam logic [SLOT_W-1:0] SLOT_N4  = 3'd4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/maxnet_job_regs.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | maxnet_job_regs : 5x32 operand register file, slot write, parallel out  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module maxnet_job_regs
  import maxnet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic [FP_W-1:0]   i_wdata,
  output logic [FP_W-1:0]   o_epsilon,
  output logic [FP_W-1:0]   o_num1,
  output logic [FP_W-1:0]   o_num2,
  output logic [FP_W-1:0]   o_num3,
  output logic [FP_W-1:0]   o_num4
);
  logic [FP_W-1:0] r_ops [NUM_SLOTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_ops[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (i_slot == SLOT_W'(i)) r_ops[i] <= i_wdata;
      end
    end
  end

  assign o_epsilon = r_ops[SLOT_EPS];
  assign o_num1    = r_ops[SLOT_N1];
  assign o_num2    = r_ops[SLOT_N2];
  assign o_num3    = r_ops[SLOT_N3];
  assign o_num4    = r_ops[SLOT_N4];
endmodule
`default_nettype wire

// File: rtl/maxnet_feeder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | maxnet_feeder : loads a Maxnet job, runs the core, returns max/latency  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module maxnet_feeder
  import maxnet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_max,
  output logic [CNT_W-1:0] out_cycles,
  output logic             out_timeout,
  output logic             busy,
  output logic             mn_rst,
  output logic             mn_start,
  output logic [FP_W-1:0]  mn_epsilon,
  output logic [FP_W-1:0]  mn_num1,
  output logic [FP_W-1:0]  mn_num2,
  output logic [FP_W-1:0]  mn_num3,
  output logic [FP_W-1:0]  mn_num4,
  input  logic [FP_W-1:0]  mn_max,
  input  logic             mn_done
);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_t            r_state;
  logic [SLOT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_out_cycles;
  logic [FP_W-1:0]   r_out_max;
  logic              r_out_timeout;
  logic              w_load_hs;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // The core stays in reset whenever the feeder itself is held in reset.
  assign in_ready    = rst & (r_state == ST_LOAD);
  assign w_load_hs   = in_valid & in_ready;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign mn_rst      = ~rst | (r_state == ST_CLEAR);
  assign mn_start    = (r_state == ST_RUN);
  assign busy        = (r_state == ST_CLEAR) | (r_state == ST_RUN);
  assign out_valid   = (r_state == ST_RESULT);
  assign out_max     = r_out_max;
  assign out_cycles  = r_out_cycles;
  assign out_timeout = r_out_timeout;

  maxnet_job_regs u_job_regs (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_load_hs),
    .i_slot    (r_load_cnt),
    .i_wdata   (in_data),
    .o_epsilon (mn_epsilon),
    .o_num1    (mn_num1),
    .o_num2    (mn_num2),
    .o_num3    (mn_num3),
    .o_num4    (mn_num4)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_LOAD;
      r_load_cnt    <= '0;
      r_cnt         <= '0;
      r_out_max     <= '0;
      r_out_cycles  <= '0;
      r_out_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_load_hs) begin
            if (r_load_cnt == SLOT_N4) begin
              r_load_cnt <= '0;
              r_state    <= ST_CLEAR;
            end else begin
              r_load_cnt <= r_load_cnt + SLOT_W'(1);
            end
          end
        end
        ST_CLEAR: begin
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_cnt <= w_cnt_nxt;
          // done is tested first so a completion on the last allowed cycle is not a timeout
          if (mn_done) begin
            r_out_max     <= mn_max;
            r_out_cycles  <= w_cnt_nxt;
            r_out_timeout <= 1'b0;
            r_state       <= ST_RESULT;
          end else if (w_cnt_nxt == C_TIMEOUT) begin
            r_out_max     <= '0;
            r_out_cycles  <= C_TIMEOUT;
            r_out_timeout <= 1'b1;
            r_state       <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            r_load_cnt <= '0;
            r_state    <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_maxnet_feeder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_maxnet_feeder : directed jobs against a Maxnet stub, per-cycle model |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_maxnet_feeder;
  localparam int TMO = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_max;
  logic [CW-1:0] out_cycles;
  logic          out_timeout;
  logic          busy;
  logic          mn_rst;
  logic          mn_start;
  logic [31:0]   mn_epsilon, mn_num1, mn_num2, mn_num3, mn_num4;
  logic [31:0]   mn_max;
  logic          mn_done;

  always #5 clk = ~clk;

  maxnet_feeder #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_cycles(out_cycles), .out_timeout(out_timeout), .busy(busy),
    .mn_rst(mn_rst), .mn_start(mn_start), .mn_epsilon(mn_epsilon),
    .mn_num1(mn_num1), .mn_num2(mn_num2), .mn_num3(mn_num3), .mn_num4(mn_num4),
    .mn_max(mn_max), .mn_done(mn_done)
  );

  // Maxnet stub: done rises in the N-th start cycle and holds; N=0 never finishes.
  int          stub_n   = 0;
  logic [31:0] stub_max = '0;
  int          scnt     = 0;
  always @(posedge clk) begin
    if (mn_rst)        scnt <= 0;
    else if (mn_start) scnt <= scnt + 1;
  end
  assign mn_done = mn_start && (stub_n > 0) && (scnt >= stub_n - 1);
  assign mn_max  = stub_max;

  // Model of the job currently in flight.
  logic [31:0] exp_ops [5];
  logic [31:0] exp_max;
  int          exp_cyc;
  logic        exp_to;
  int          vectors    = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  int   rst_len   = 0;
  int   start_len = 0;
  logic prev_ov   = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      rst_len   = 0;
      start_len = 0;
      prev_ov   = 1'b0;
    end else begin
      if (busy || out_valid) begin
        chk("mn_epsilon", {32'd0, mn_epsilon}, {32'd0, exp_ops[0]});
        chk("mn_num1", {32'd0, mn_num1}, {32'd0, exp_ops[1]});
        chk("mn_num2", {32'd0, mn_num2}, {32'd0, exp_ops[2]});
        chk("mn_num3", {32'd0, mn_num3}, {32'd0, exp_ops[3]});
        chk("mn_num4", {32'd0, mn_num4}, {32'd0, exp_ops[4]});
        chk("in_ready_not_load", {63'd0, in_ready}, 64'd0);
      end
      if (mn_rst) begin
        rst_len++;
        start_len = 0;
      end else if (rst_len != 0) begin
        chk("mn_rst_pulse_len", 64'(rst_len), 64'd1);
        chk("start_after_clear", {63'd0, mn_start}, 64'd1);
        rst_len = 0;
      end
      if (mn_start) start_len++;
      if (out_valid) begin
        chk("out_max", {32'd0, out_max}, {32'd0, exp_max});
        chk("out_cycles", 64'(out_cycles), 64'(exp_cyc));
        chk("out_timeout", {63'd0, out_timeout}, {63'd0, exp_to});
        chk("start_low_in_result", {63'd0, mn_start}, 64'd0);
        chk("busy_low_in_result", {63'd0, busy}, 64'd0);
        if (!prev_ov) chk("start_high_cycles", 64'(start_len), 64'(exp_cyc));
      end
      prev_ov = out_valid;
    end
  end

  task automatic send_word(input int slot, input logic [31:0] w);
    int k;
    exp_ops[slot] = w;
    in_valid = 1'b1;
    in_data  = w;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_for_word", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_job(input logic [4:0][31:0] words, input int gap);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) repeat (gap) begin
        @(posedge clk); #1;
      end
      send_word(i, words[4-i]);
    end
  endtask

  // words packed as {eps, n1, n2, n3, n4}
  task automatic run_job(input logic [4:0][31:0] words, input int n, input logic [31:0] mx,
                         input int gap, input int hold);
    int k;
    stub_n   = n;
    stub_max = mx;
    if (n > 0 && n <= TMO) begin
      exp_max = mx; exp_cyc = n;   exp_to = 1'b0;
    end else begin
      exp_max = '0; exp_cyc = TMO; exp_to = 1'b1;
    end
    load_job(words, gap);
    k = 0;
    while (!out_valid && k < TMO + 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("result_arrives", {63'd0, out_valid}, 64'd1);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("out_valid_held", {63'd0, out_valid}, 64'd1);
      chk("in_ready_held", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_accept", {63'd0, out_valid}, 64'd0);
    chk("in_ready_after_accept", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 5; i++) exp_ops[i] = '0;
    exp_max = '0; exp_cyc = 0; exp_to = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mn_rst", {63'd0, mn_rst}, 64'd1);
    chk("rst_mn_start", {63'd0, mn_start}, 64'd0);
    chk("rst_out_max", {32'd0, out_max}, 64'd0);
    chk("rst_out_cycles", 64'(out_cycles), 64'd0);
    chk("rst_mn_num4", {32'd0, mn_num4}, 64'd0);
    rst = 1'b1;
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_mn_rst", {63'd0, mn_rst}, 64'd0);

    // Normal job
    run_job({32'h3E99999A, 32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666},
            7, 32'h3F4CCCCD, 0, 0);
    chk("lit_max_normal", {32'd0, out_max}, 64'h3F4CCCCD);
    chk("lit_cycles_normal", 64'(out_cycles), 64'd7);
    chk("lit_to_normal", {63'd0, out_timeout}, 64'd0);
    chk("lit_eps_normal", {32'd0, mn_epsilon}, 64'h3E99999A);
    chk("lit_num3_normal", {32'd0, mn_num3}, 64'h3FD9999A);

    // Timeout
    run_job({32'h3E99999A, 32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666},
            0, 32'h12345678, 0, 0);
    chk("lit_max_timeout", {32'd0, out_max}, 64'd0);
    chk("lit_cycles_timeout", 64'(out_cycles), 64'd16);
    chk("lit_to_timeout", {63'd0, out_timeout}, 64'd1);

    // Input gap and output backpressure
    run_job({32'h3C23D70A, 32'hBF800000, 32'h40000000, 32'h7F800000, 32'h00000001},
            4, 32'h40490FDB, 3, 5);
    chk("lit_num1_bp", {32'd0, mn_num1}, 64'hBF800000);
    chk("lit_num2_bp", {32'd0, mn_num2}, 64'h40000000);
    chk("lit_cycles_bp", 64'(out_cycles), 64'd4);

    // Done exactly on the timeout edge, then one cycle too late
    run_job({32'h00000000, 32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000},
            16, 32'h3F800000, 0, 1);
    chk("lit_to_edge", {63'd0, out_timeout}, 64'd0);
    chk("lit_cycles_edge", 64'(out_cycles), 64'd16);
    run_job({32'h00000000, 32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000},
            17, 32'h3F800000, 0, 0);
    chk("lit_to_late", {63'd0, out_timeout}, 64'd1);

    // Bit-exact passthrough of -0 and NaN, one-cycle completion
    run_job({32'h7FC00001, 32'h80000000, 32'hFFFFFFFF, 32'h00800000, 32'h7F7FFFFF},
            1, 32'h80000000, 0, 0);
    chk("lit_max_negzero", {32'd0, out_max}, 64'h80000000);
    chk("lit_eps_nan", {32'd0, mn_epsilon}, 64'h7FC00001);
    chk("lit_cycles_one", 64'(out_cycles), 64'd1);

    // Reset during RUN
    stub_n = 0;
    load_job({32'h3E99999A, 32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666}, 0);
    k = 0;
    while (!mn_start && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("midrun_started", {63'd0, mn_start}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrun_start_drop", {63'd0, mn_start}, 64'd0);
    chk("midrun_mn_rst", {63'd0, mn_rst}, 64'd1);
    chk("midrun_busy", {63'd0, busy}, 64'd0);
    chk("midrun_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_operands", {32'd0, mn_num2}, 64'd0);
    run_job({32'h3E99999A, 32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666},
            3, 32'h7FC00001, 0, 2);
    chk("lit_max_after_rst", {32'd0, out_max}, 64'h7FC00001);
    chk("lit_cycles_after_rst", 64'(out_cycles), 64'd3);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
